// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared state and LED pattern encodings for the tug-of-war match controller
package tow_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT      = 3'd1,
    ST_DARK      = 3'd2,
    ST_PLAY      = 3'd3,
    ST_GLOAT     = 3'd4,
    ST_MATCH_END = 3'd5
  } tow_state_t;

  localparam logic [1:0] LC_ALL  = 2'b11;
  localparam logic [1:0] LC_OFF  = 2'b00;
  localparam logic [1:0] LC_ROPE = 2'b10;
  localparam logic [1:0] LC_WIN  = 2'b01;

endpackage

// File: rtl/tow_tick_counter.sv
// rtl/tow_tick_counter.sv - slowen-gated phase counter that stops at its target
module tow_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count >= target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !tc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/tow_match_ctrl.sv
// rtl/tow_match_ctrl.sv - tug-of-war match sequencer with per-side round scores
module tow_match_ctrl
  import tow_pkg::*;
#(
  parameter int WAIT_TICKS    = 2,
  parameter int GLOAT_TICKS   = 2,
  parameter int DARK_MIN      = 1,
  parameter int ROUNDS_TO_WIN = 3,
  parameter int SCORE_W       = 3,
  parameter int TICK_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slowen,
  input  logic               rout,
  input  logic               winrnd,
  input  logic               win_side,
  input  logic               new_match,
  output logic               clear,
  output logic               leds_on,
  output logic [1:0]         led_control,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over,
  output logic               match_winner
);

  // Counter targets are "last index" values so the terminal flag marks the Nth slowen.
  localparam logic [TICK_W-1:0]  WAIT_T  = TICK_W'(WAIT_TICKS - 1);
  localparam logic [TICK_W-1:0]  GLOAT_T = TICK_W'(GLOAT_TICKS - 1);
  localparam logic [TICK_W-1:0]  DARK_T  = TICK_W'(DARK_MIN);
  localparam logic [SCORE_W-1:0] WIN_CNT = SCORE_W'(ROUNDS_TO_WIN);

  tow_state_t         state, state_nx;
  logic [TICK_W-1:0]  tick, tick_target;
  logic               tick_en, tick_tc, tick_clr;
  logic               win_take, match_done;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  tow_tick_counter #(.W(TICK_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (tick_clr),
    .en     (tick_en),
    .target (tick_target),
    .count  (tick),
    .tc     (tick_tc)
  );

  assign win_take    = winrnd && ((state == ST_DARK) || (state == ST_PLAY));
  assign match_done  = (score_l == WIN_CNT) || (score_r == WIN_CNT);
  assign score_l_inc = (score_l == '1) ? score_l : score_l + 1'b1;
  assign score_r_inc = (score_r == '1) ? score_r : score_r + 1'b1;
  assign tick_clr    = (state_nx != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_RESET;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    tick_en     = 1'b0;
    tick_target = '0;
    case (state)
      ST_RESET: state_nx = ST_WAIT;
      ST_WAIT: begin
        tick_en     = slowen;
        tick_target = WAIT_T;
        if (slowen && tick_tc)
          state_nx = ST_DARK;
      end
      ST_DARK: begin
        tick_target = DARK_T;
        // A win during DARK is a false start and pre-empts any start request.
        if (winrnd)
          state_nx = ST_GLOAT;
        else begin
          tick_en = slowen;
          if (slowen && rout && tick_tc)
            state_nx = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (winrnd)
          state_nx = ST_GLOAT;
      end
      ST_GLOAT: begin
        tick_en     = slowen;
        tick_target = GLOAT_T;
        if (slowen && tick_tc)
          state_nx = match_done ? ST_MATCH_END : ST_DARK;
      end
      ST_MATCH_END: begin
        if (new_match)
          state_nx = ST_WAIT;
      end
      default: state_nx = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_l      <= '0;
      score_r      <= '0;
      match_winner <= 1'b0;
    end else if ((state == ST_MATCH_END) && new_match) begin
      score_l      <= '0;
      score_r      <= '0;
      match_winner <= 1'b0;
    end else if (win_take) begin
      if (!win_side) begin
        score_l <= score_l_inc;
        if (score_l_inc == WIN_CNT)
          match_winner <= 1'b0;
      end else begin
        score_r <= score_r_inc;
        if (score_r_inc == WIN_CNT)
          match_winner <= 1'b1;
      end
    end
  end

  always_comb begin
    leds_on     = 1'b1;
    clear       = 1'b1;
    led_control = LC_ALL;
    case (state)
      ST_DARK: begin
        leds_on     = 1'b0;
        clear       = 1'b0;
        led_control = LC_OFF;
      end
      ST_PLAY: begin
        clear       = 1'b0;
        led_control = LC_ROPE;
      end
      ST_GLOAT:     led_control = LC_ROPE;
      ST_MATCH_END: led_control = LC_WIN;
      default:      led_control = LC_ALL;
    endcase
  end

  assign match_over = (state == ST_MATCH_END);

endmodule

// File: tb/tb_tow_match_ctrl.sv
// tb/tb_tow_match_ctrl.sv - directed self-checking bench for tow_match_ctrl
module tb_tow_match_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slowen = 1'b0, rout = 1'b0, winrnd = 1'b0, win_side = 1'b0, new_match = 1'b0;
  logic       clear, leds_on, match_over, match_winner;
  logic [1:0] led_control;
  logic [2:0] score_l, score_r;

  int n_cmp = 0;
  int n_err = 0;

  tow_match_ctrl #(
    .WAIT_TICKS(2), .GLOAT_TICKS(2), .DARK_MIN(1), .ROUNDS_TO_WIN(3), .SCORE_W(3), .TICK_W(4)
  ) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .rout(rout), .winrnd(winrnd), .win_side(win_side),
    .new_match(new_match), .clear(clear), .leds_on(leds_on), .led_control(led_control),
    .score_l(score_l), .score_r(score_r), .match_over(match_over), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output vector {leds_on, clear, led_control}
  function automatic int outs();
    return int'({leds_on, clear, led_control});
  endfunction

  task automatic drive(input logic s, input logic r, input logic w, input logic ws, input logic nm);
    slowen = s; rout = r; winrnd = w; win_side = ws; new_match = nm;
    @(posedge clk); #1;
    slowen = 0; rout = 0; winrnd = 0; new_match = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  // Three idle cycles then a slowen pulse: slowen every 4 clk.
  task automatic tick(input logic r);
    idle(3);
    drive(1, r, 0, 0, 0);
  endtask

  task automatic win(input logic side);
    drive(0, 0, 1, side, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", outs(), 'hF);
    check("rst_score_l", score_l, 0);
    check("rst_score_r", score_r, 0);
    check("rst_match_over", match_over, 0);

    rst = 0;
    idle(1);
    check("wait_outs", outs(), 'hF);
    tick(0);
    check("wait_after_1st_tick", outs(), 'hF);
    tick(0);
    check("dark_outs", outs(), 'h0);

    tick(1);
    check("dark_min_hold", outs(), 'h0);
    drive(0, 1, 0, 0, 0);
    check("rout_no_slowen", outs(), 'h0);
    tick(1);
    check("play_outs", outs(), 'hA);
    tick(1);
    check("play_ignores_slowen", outs(), 'hA);

    win(1);
    check("gloat_outs", outs(), 'hE);
    check("gloat_score_r", score_r, 1);
    check("gloat_score_l", score_l, 0);
    win(0);
    check("gloat_ignores_win", score_l, 0);
    tick(0);
    check("gloat_1st_tick", outs(), 'hE);
    tick(0);
    check("gloat_to_dark", outs(), 'h0);

    drive(1, 1, 1, 0, 0);
    check("win_slowen_rout_outs", outs(), 'hE);
    check("win_slowen_rout_score_l", score_l, 1);
    tick(0); tick(0);
    win(0);
    check("false_start_score_l", score_l, 2);
    tick(0); tick(0);
    tick(1); tick(1);
    check("play_again", outs(), 'hA);
    win(0);
    check("third_win_score_l", score_l, 3);
    check("third_win_not_over", match_over, 0);
    tick(0); tick(0);
    check("match_end_outs", outs(), 'hD);
    check("match_over", match_over, 1);
    check("match_winner", match_winner, 0);
    drive(1, 1, 1, 1, 0);
    check("match_end_ignores_win", score_r, 1);
    check("match_end_hold", outs(), 'hD);
    drive(0, 0, 0, 0, 1);
    check("new_match_outs", outs(), 'hF);
    check("new_match_score_l", score_l, 0);
    check("new_match_score_r", score_r, 0);
    check("new_match_over", match_over, 0);

    tick(0); tick(0);
    win(0);
    tick(0); tick(0);
    win(0);
    tick(0); tick(0);
    tick(1); tick(1);
    check("pre_rst_play", outs(), 'hA);
    check("pre_rst_score_l", score_l, 2);
    rst = 1;
    #1;
    check("async_rst_outs", outs(), 'hF);
    check("async_rst_score_l", score_l, 0);
    @(posedge clk); #1;
    rst = 0;
    idle(1);
    check("post_rst_wait", outs(), 'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
